// File: rtl/ml_acc_axil_regs.sv
// AXI4-Lite register file for the ML accelerator: config words,
// start/done control, status, run-cycle counter and version.
module ml_acc_axil_regs #(
    parameter int          C_ADDR_WIDTH = 6,
    parameter logic [31:0] C_VERSION    = 32'h0001_0000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [319:0]            cfg_o,
    output logic                    start_o,
    input  logic                    done_i,
    output logic                    irq_o
);

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rstate_t;

    wstate_t     w_state, w_next;
    rstate_t     r_state, r_next;
    logic [31:0] cfg [10];
    logic        ie, busy, done;
    logic [31:0] cycles;
    logic        start_r;
    logic [31:0] rd_val;
    logic [3:0]  wr_idx, rd_idx;
    logic        wr_fire, rd_fire, start_fire, done_clr;
    logic        unused_addr_lsbs;

    assign wr_idx  = S_AXI_AWADDR[5:2];
    assign rd_idx  = S_AXI_ARADDR[5:2];
    assign wr_fire = (w_state == W_ACCEPT);
    assign rd_fire = (r_state == R_ACCEPT);

    assign start_fire = wr_fire && wr_idx == 4'd10 && S_AXI_WSTRB[0]
                        && S_AXI_WDATA[0] && !busy;
    assign done_clr   = wr_fire && wr_idx == 4'd11 && S_AXI_WSTRB[0]
                        && S_AXI_WDATA[1];

    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = rd_fire;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = 2'b00;
    assign start_o       = start_r;
    assign irq_o         = done & ie;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar k = 0; k < 10; k++) begin : g_cfg
        assign cfg_o[32*k +: 32] = cfg[k];
    end

    // Write channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write channel next state: accept AW and W only together
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_next = W_ACCEPT;
            W_ACCEPT: w_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // Read channel state register
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read channel next state
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:   if (S_AXI_ARVALID) r_next = R_ACCEPT;
            R_ACCEPT: r_next = R_DATA;
            R_DATA:   if (S_AXI_RREADY) r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // Read mux over the current (pre-write) register values
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < 10; k++) begin
            if (rd_idx == 4'(k)) rd_val = cfg[k];
        end
        case (rd_idx)
            4'd10:   rd_val = {30'd0, ie, 1'b0};
            4'd11:   rd_val = {30'd0, done, busy};
            4'd12:   rd_val = cycles;
            4'd13:   rd_val = C_VERSION;
            default: ;
        endcase
    end

    // Read data is captured on the address handshake and held
    always_ff @(posedge ACLK) begin
        if (ARESET)       S_AXI_RDATA <= '0;
        else if (rd_fire) S_AXI_RDATA <= rd_val;
    end

    // Config, control, status and cycle counter
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < 10; k++) cfg[k] <= '0;
            ie      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cycles  <= '0;
            start_r <= 1'b0;
        end else begin
            start_r <= start_fire;
            for (int k = 0; k < 10; k++) begin
                if (wr_fire && wr_idx == 4'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (S_AXI_WSTRB[b])
                            cfg[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
            if (wr_fire && wr_idx == 4'd10 && S_AXI_WSTRB[0])
                ie <= S_AXI_WDATA[1];
            if (start_fire)  busy <= 1'b1;
            else if (done_i) busy <= 1'b0;
            // A completion pulse always wins over clearing DONE
            if (done_i)          done <= 1'b1;
            else if (start_fire) done <= 1'b0;
            else if (done_clr)   done <= 1'b0;
            if (start_fire) cycles <= '0;
            else if (busy)  cycles <= cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_ml_acc_axil_regs.sv
// Self-checking bench for ml_acc_axil_regs: vector table, random
// config traffic against a register model, and start/done sequences.
module tb_ml_acc_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [5:0]   awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [5:0]   araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [319:0] cfg_o;
    logic         start_o;
    logic         done_i = 1'b0;
    logic         irq_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_hi = 0;
    int start_cyc = 0;
    int done_cyc = 0;

    logic [31:0] cfg_m [10];
    logic        ie_m;

    ml_acc_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .cfg_o(cfg_o), .start_o(start_o),
        .done_i(done_i), .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    // Pulse and timestamp monitor
    always @(posedge ACLK) begin
        if (start_o) begin
            start_hi  = start_hi + 1;
            start_cyc = cyc;
        end
        if (done_i) done_cyc = cyc;
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_reg(input int idx);
        if (idx < 10)  return cfg_m[idx];
        if (idx == 10) return {30'd0, ie_m, 1'b0};
        if (idx == 13) return 32'h0001_0000;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 10; k++) cfg_m[k] = '0;
        ie_m = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit coincide);
        int n;
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        while (!awready && n < 20) begin @(negedge ACLK); n++; end
        chk("awready", {31'd0, awready}, 32'd1);
        chk("wready", {31'd0, wready}, 32'd1);
        if (coincide) done_i = 1;
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; done_i = 0; bready = 1;
        if (a[5:2] < 10) cfg_m[a[5:2]] = merge(cfg_m[a[5:2]], d, s);
        if (a[5:2] == 10 && s[0]) ie_m = d[1];
        @(negedge ACLK);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        @(posedge ACLK); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        araddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge ACLK); n++; end
        if (!arready) chk("arready_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        arvalid = 0; rready = 1;
        @(negedge ACLK);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge ACLK); n++; end
        if (!rvalid) chk("rvalid_timeout", 32'd0, 32'd1);
        chk("rresp", {30'd0, rresp}, 32'd0);
        d = rdata;
        @(posedge ACLK); #1;
        rready = 0;
    endtask

    task automatic pulse_done();
        @(negedge ACLK); done_i = 1;
        @(negedge ACLK); done_i = 0;
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [31:0] rd;
        logic [31:0] held;
        int          n0, n;

        model_reset();
        tbl[0] = '{6'h08, 32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
        tbl[1] = '{6'h00, 32'h12345678, 4'b1111, 32'h12345678};
        tbl[2] = '{6'h24, 32'hA5A5A5A5, 4'b1000, 32'hA5000000};
        tbl[3] = '{6'h38, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
        tbl[4] = '{6'h34, 32'h00000000, 4'b1111, 32'h00010000};
        tbl[5] = '{6'h14, 32'hCAFEF00D, 4'b0110, 32'h00FEF000};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        chk("rst_ready", {30'd0, awready, arready}, 32'd0);
        chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_out", {30'd0, start_o, irq_o}, 32'd0);
        chk("rst_cfg", {31'd0, cfg_o != '0}, 32'd0);

        axi_read(6'h34, rd); chk("version", rd, 32'h0001_0000);
        axi_read(6'h2C, rd); chk("status_rst", rd, 32'd0);
        axi_read(6'h38, rd); chk("reg14", rd, 32'd0);

        for (int i = 0; i < 6; i++) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0);
            axi_read(tbl[i].addr, rd);
            chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
            if (tbl[i].addr[5:2] < 10)
                chk($sformatf("tbl%0d_cfg", i),
                    cfg_o[32*tbl[i].addr[5:2] +: 32], tbl[i].exp);
        end

        for (int i = 0; i < 60; i++) begin
            int idx;
            if ($urandom_range(1) == 0) begin
                idx = $urandom_range(13);
                if (idx >= 10) idx = idx + 2;
                axi_write(6'(idx * 4), $urandom, 4'($urandom), 0);
            end else begin
                idx = $urandom_range(15);
                if (idx == 11 || idx == 12) idx = 0;
                axi_read(6'(idx * 4), rd);
                chk($sformatf("rand_r%0d", idx), rd, exp_reg(idx));
            end
        end
        for (int k = 0; k < 10; k++)
            chk($sformatf("cfg_o%0d", k), cfg_o[32*k +: 32], cfg_m[k]);

        n0 = start_hi;
        axi_write(6'h28, 32'd1, 4'b0001, 0);
        repeat (3) @(negedge ACLK);
        chk("start_once", 32'(start_hi - n0), 32'd1);
        axi_read(6'h2C, rd); chk("busy", rd, 32'd1);
        repeat (40) @(negedge ACLK);
        pulse_done();
        axi_read(6'h2C, rd); chk("done", rd, 32'd2);
        axi_read(6'h30, rd);
        chk("cycles", rd, 32'(done_cyc - start_cyc + 1));
        chk("cycles_range", {31'd0, rd >= 38 && rd <= 140}, 32'd1);
        chk("irq_off", {31'd0, irq_o}, 32'd0);

        axi_write(6'h28, 32'd3, 4'b0001, 0);
        axi_read(6'h2C, rd); chk("restart", rd, 32'd1);
        pulse_done();
        @(negedge ACLK); chk("irq_on", {31'd0, irq_o}, 32'd1);
        axi_write(6'h2C, 32'd2, 4'b0001, 0);
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
        axi_read(6'h2C, rd); chk("w1c", rd, 32'd0);
        axi_write(6'h28, 32'd3, 4'b0001, 0);
        axi_write(6'h2C, 32'd2, 4'b0001, 1);
        axi_read(6'h2C, rd); chk("set_wins", rd, 32'd2);
        chk("irq_kept", {31'd0, irq_o}, 32'd1);
        axi_read(6'h28, rd); chk("ctrl_rd", rd, 32'd2);

        n0 = start_hi;
        axi_write(6'h28, 32'd1, 4'b0001, 0);
        axi_write(6'h28, 32'd1, 4'b0001, 0);
        axi_write(6'h28, 32'd1, 4'b0001, 0);
        repeat (2) @(negedge ACLK);
        chk("one_pulse", 32'(start_hi - n0), 32'd1);
        axi_read(6'h28, rd); chk("ie_upd", rd, 32'd0);
        axi_read(6'h2C, rd); chk("busy2", rd, 32'd1);
        pulse_done();

        @(negedge ACLK);
        awaddr = 6'h04; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        n = 0;
        while (!awready && n < 20) begin @(negedge ACLK); n++; end
        chk("stall_aw", {31'd0, awready}, 32'd1);
        cfg_m[1] = 32'h0BADF00D;
        @(posedge ACLK); #1;
        awaddr = 6'h00; wdata = 32'h11111111;
        repeat (5) begin
            @(negedge ACLK);
            chk("b_hold", {30'd0, bvalid, awready}, 32'd2);
        end
        awvalid = 0; wvalid = 0; bready = 1;
        @(posedge ACLK); #1 bready = 0;
        axi_read(6'h00, rd); chk("no_2nd_wr", rd, cfg_m[0]);

        @(negedge ACLK);
        araddr = 6'h04; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge ACLK); n++; end
        chk("stall_ar", {31'd0, arready}, 32'd1);
        @(posedge ACLK); #1 arvalid = 0;
        @(negedge ACLK);
        held = rdata;
        chk("r_data", held, 32'h0BADF00D);
        repeat (5) begin
            @(negedge ACLK);
            chk("r_hold", {31'd0, rvalid}, 32'd1);
            chk("r_stable", rdata, held);
        end
        rready = 1;
        @(posedge ACLK); #1 rready = 0;

        @(negedge ACLK);
        awaddr = 6'h00; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge ACLK);
            if (awready) begin awvalid = 0; wvalid = 0; end
            n++;
        end
        chk("pre_rst_b", {31'd0, bvalid}, 32'd1);
        awvalid = 0; wvalid = 0;
        ARESET = 1;
        @(negedge ACLK);
        chk("rst_drop_b", {31'd0, bvalid}, 32'd0);
        ARESET = 0;
        model_reset();
        @(negedge ACLK);
        chk("rst_cfg2", {31'd0, cfg_o != '0}, 32'd0);
        axi_read(6'h2C, rd); chk("rst_status", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
